pilot_avg_acc: RTL and testbench

//  Complex pilot averager for channel estimation.
//  - Accumulates 2**LOG2_AVG consecutive signed I/Q pilot samples that belong to one estimate slot.
//  - Writes the rounded/truncated mean into a DEPTH-entry estimate bank.
//  - Bank is read through a combinational read port by the interpolation stage.
//  - Generalises the fixed 2-pilot, 4-entry, single-rail averager: count, depth, I/Q, handshake, error flag.

---
 rtl/pilot_avg_acc_if.sv | 28 ++
 rtl/pilot_avg_acc.sv | 234 +++++++++++++++++++++++
 tb/tb_pilot_avg_acc.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pilot_avg_acc_if.sv
// Pilot sample stream between the pilot extractor and the averager.
// The master drives samples, the slave returns in_ready.
interface pilot_avg_acc_if #(
    parameter int WIDTH_PILOT = 16,
    parameter int ADDR_W      = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [WIDTH_PILOT-1:0] in_re;
    logic signed [WIDTH_PILOT-1:0] in_im;
    logic        [ADDR_W-1:0]      in_addr;

    modport master (
        output in_valid,
        output in_re,
        output in_im,
        output in_addr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_re,
        input  in_im,
        input  in_addr,
        output in_ready
    );
endinterface

// File: rtl/pilot_avg_acc.sv
// Complex pilot averager: averages 2**LOG2_AVG I/Q pilots per slot into a DEPTH-entry bank.
// Optional feature macro: PILOT_AVG_ROUND_EN (round-half-up with saturation instead of truncation).
module pilot_avg_acc #(
    parameter int WIDTH_PILOT = 16,
    parameter int WIDTH_EST   = 17,
    parameter int LOG2_AVG    = 1,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    pilot_avg_acc_if.slave              in_bus,
    output logic                        wr_done,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic                        addr_err,
    output logic                        bank_full,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic signed [WIDTH_EST-1:0] rd_re,
    output logic signed [WIDTH_EST-1:0] rd_im
);

    localparam int AW    = WIDTH_PILOT + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0]  GROUP_N = CNT_W'(2 ** LOG2_AVG);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic                         hs_s;
    logic                         start_s;
    logic                         add_s;
    logic                         err_s;
    logic                         wr_s;
    logic signed [AW-1:0]         samp_re_s;
    logic signed [AW-1:0]         samp_im_s;
    logic signed [AW-1:0]         acc_re_r;
    logic signed [AW-1:0]         acc_im_r;
    logic        [CNT_W-1:0]      cnt_r;
    logic        [ADDR_W-1:0]     addr_r;
    logic                         in_ready_r;
    logic                         wr_done_r;
    logic                         addr_err_r;
    logic                         bank_full_r;
    logic        [DEPTH-1:0]      written_r;
    logic        [DEPTH-1:0]      wr_mask_s;
    logic signed [WIDTH_EST-1:0]  mean_re_s;
    logic signed [WIDTH_EST-1:0]  mean_im_s;
    logic signed [WIDTH_EST-1:0]  est_re_r [DEPTH];
    logic signed [WIDTH_EST-1:0]  est_im_r [DEPTH];

`ifdef PILOT_AVG_ROUND_EN
    localparam int WW     = AW + 1;
    localparam int CW     = ((WW > WIDTH_EST) ? WW : WIDTH_EST) + 1;
    localparam int HALF_I = (LOG2_AVG == 0) ? 0 : (1 << (LOG2_AVG - 1));
    localparam logic signed [WW-1:0] HALF    = WW'(HALF_I);
    localparam logic signed [CW-1:0] EST_MAX = {{(CW - WIDTH_EST + 1){1'b0}}, {(WIDTH_EST - 1){1'b1}}};
    localparam logic signed [CW-1:0] EST_MIN = {{(CW - WIDTH_EST + 1){1'b1}}, {(WIDTH_EST - 1){1'b0}}};

    function automatic logic signed [WIDTH_EST-1:0] sat_est(input logic signed [WW-1:0] v);
        logic signed [CW-1:0] ve;
        ve = {{(CW - WW){v[WW-1]}}, v};
        if (ve > EST_MAX) begin
            sat_est = EST_MAX[WIDTH_EST-1:0];
        end else if (ve < EST_MIN) begin
            sat_est = EST_MIN[WIDTH_EST-1:0];
        end else begin
            sat_est = ve[WIDTH_EST-1:0];
        end
    endfunction

    // The extra accumulator bit keeps the rounding offset from wrapping the sum.
    function automatic logic signed [WIDTH_EST-1:0] mean_of(input logic signed [AW-1:0] acc);
        logic signed [WW-1:0] s;
        s = $signed({acc[AW-1], acc}) + HALF;
        s = s >>> LOG2_AVG;
        mean_of = sat_est(s);
    endfunction
`else
    // Dropping the low LOG2_AVG bits is the floor division; the result always fits WIDTH_PILOT.
    function automatic logic signed [WIDTH_EST-1:0] mean_of(input logic signed [AW-1:0] acc);
        mean_of = WIDTH_EST'($signed(acc[AW-1:LOG2_AVG]));
    endfunction
`endif

    assign hs_s            = in_bus.in_valid & in_ready_r;
    assign samp_re_s       = AW'(in_bus.in_re);
    assign samp_im_s       = AW'(in_bus.in_im);
    assign in_bus.in_ready = in_ready_r;
    assign wr_done         = wr_done_r;
    assign wr_addr         = addr_r;
    assign addr_err        = addr_err_r;
    assign bank_full       = bank_full_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and group control decode; clear aborts everything in flight.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        add_s       = 1'b0;
        err_s       = 1'b0;
        wr_s        = 1'b0;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        start_s     = 1'b1;
                        state_nxt_s = (LOG2_AVG == 0) ? ST_WR : ST_ACC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (hs_s && (in_bus.in_addr == addr_r)) begin
                        add_s       = 1'b1;
                        state_nxt_s = ((cnt_r + CNT_W'(1)) == GROUP_N) ? ST_WR : ST_ACC;
                    end else if (hs_s) begin
                        err_s       = 1'b1;
                        start_s     = 1'b1;
                        state_nxt_s = ST_ACC;
                    end else begin
                        state_nxt_s = ST_ACC;
                    end
                end
                ST_WR: begin
                    wr_s        = ({1'b0, addr_r} < DEPTH_V);
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Accumulators, group counter, latched slot and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re_r   <= '0;
            acc_im_r   <= '0;
            cnt_r      <= '0;
            addr_r     <= '0;
            in_ready_r <= 1'b1;
            wr_done_r  <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s != ST_WR);
            wr_done_r  <= (state_nxt_s == ST_WR);
            addr_err_r <= err_s;
            if (clear) begin
                acc_re_r <= '0;
                acc_im_r <= '0;
                cnt_r    <= '0;
                addr_r   <= '0;
            end else if (start_s) begin
                acc_re_r <= samp_re_s;
                acc_im_r <= samp_im_s;
                cnt_r    <= CNT_W'(1);
                addr_r   <= in_bus.in_addr;
            end else if (add_s) begin
                acc_re_r <= acc_re_r + samp_re_s;
                acc_im_r <= acc_im_r + samp_im_s;
                cnt_r    <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r    <= cnt_r;
            end
        end
    end

    // One-hot write strobe per bank entry plus the means to store.
    always_comb begin
        wr_mask_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_mask_s[i] = wr_s & (addr_r == ADDR_W'(i));
        end
        mean_re_s = mean_of(acc_re_r);
        mean_im_s = mean_of(acc_im_r);
    end

    // Estimate bank, written bitmap and the full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                est_re_r[i] <= '0;
                est_im_r[i] <= '0;
            end
            written_r   <= '0;
            bank_full_r <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                est_re_r[i] <= '0;
                est_im_r[i] <= '0;
            end
            written_r   <= '0;
            bank_full_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_mask_s[i]) begin
                    est_re_r[i] <= mean_re_s;
                    est_im_r[i] <= mean_im_s;
                end
            end
            written_r   <= written_r | wr_mask_s;
            bank_full_r <= &(written_r | wr_mask_s);
        end
    end

    // Combinational read port; unmapped addresses read as zero.
    always_comb begin
        rd_re = '0;
        rd_im = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_re = (rd_addr == ADDR_W'(i)) ? est_re_r[i] : rd_re;
            rd_im = (rd_addr == ADDR_W'(i)) ? est_im_r[i] : rd_im;
        end
    end

endmodule

// File: tb/tb_pilot_avg_acc.sv
// Scoreboard bench for pilot_avg_acc: dut1 averages pairs over 4 slots, dut2 averages
// groups of four over 3 slots so that slot address 3 is out of range.
module tb_pilot_avg_acc;
    localparam int WP  = 16;
    localparam int WE  = 17;
    localparam int AWD = 2;
`ifdef PILOT_AVG_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        int addr;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr1 = 1'b0;
    logic clr2 = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  wq1[$];
    ev_t  wq2[$];
    ev_t  eq1[$];

    logic                 wr_done1, addr_err1, bank_full1;
    logic                 wr_done2, addr_err2, bank_full2;
    logic [AWD-1:0]       wr_addr1, wr_addr2;
    logic [AWD-1:0]       rd1 = '0;
    logic [AWD-1:0]       rd2 = '0;
    logic signed [WE-1:0] rd_re1, rd_im1, rd_re2, rd_im2;

    pilot_avg_acc_if #(.WIDTH_PILOT(WP), .ADDR_W(AWD)) b1();
    pilot_avg_acc_if #(.WIDTH_PILOT(WP), .ADDR_W(AWD)) b2();

    pilot_avg_acc #(.WIDTH_PILOT(WP), .WIDTH_EST(WE), .LOG2_AVG(1), .DEPTH(4), .ADDR_W(AWD)) dut1 (
        .clk(clk), .rst(rst), .clear(clr1), .in_bus(b1),
        .wr_done(wr_done1), .wr_addr(wr_addr1), .addr_err(addr_err1), .bank_full(bank_full1),
        .rd_addr(rd1), .rd_re(rd_re1), .rd_im(rd_im1)
    );

    pilot_avg_acc #(.WIDTH_PILOT(WP), .WIDTH_EST(WE), .LOG2_AVG(2), .DEPTH(3), .ADDR_W(AWD)) dut2 (
        .clk(clk), .rst(rst), .clear(clr2), .in_bus(b2),
        .wr_done(wr_done2), .wr_addr(wr_addr2), .addr_err(addr_err2), .bank_full(bank_full2),
        .rd_addr(rd2), .rd_re(rd_re2), .rd_im(rd_im2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
    endtask

    // Presents one sample and returns once it is accepted; k is the cycle stamp before the accepting edge.
    task automatic send(input bit sel, input int a, input int re, input int im,
                        output int k, output int waits);
        logic rdy;
        if (sel) begin
            b2.in_valid = 1'b1; b2.in_addr = AWD'(a); b2.in_re = WP'(re); b2.in_im = WP'(im);
        end else begin
            b1.in_valid = 1'b1; b1.in_addr = AWD'(a); b1.in_re = WP'(re); b1.in_im = WP'(im);
        end
        waits = 0;
        rdy   = 1'b0;
        while (!rdy && waits <= 20) begin
            @(negedge clk);
            rdy = sel ? b2.in_ready : b1.in_ready;
            if (!rdy) waits++;
        end
        if (!rdy) chk("send_timeout", 0, 1);
        k = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic readchk(input bit sel, input int a, input int re, input int im, input string nm);
        if (sel) rd2 = AWD'(a); else rd1 = AWD'(a);
        #1;
        chk({nm, "_re"}, sel ? int'(rd_re2) : int'(rd_re1), re);
        chk({nm, "_im"}, sel ? int'(rd_im2) : int'(rd_im1), im);
    endtask

    // Two-sample group on dut1 with its write expectation queued.
    task automatic pair1(input int a, input int r0, input int i0, input int r1, input int i1);
        int k, w;
        send(1'b0, a, r0, i0, k, w);
        send(1'b0, a, r1, i1, k, w);
        wq1.push_back('{addr: a, cyc: k + 1});
    endtask

    // Four identical samples on dut2 with its write expectation queued.
    task automatic quad2(input int a, input int re, input int im);
        int k, w;
        for (int j = 0; j < 4; j++) send(1'b1, a, re, im, k, w);
        wq2.push_back('{addr: a, cyc: k + 1});
    endtask

    // Scoreboard monitor for dut1 write and address-error pulses.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wq1.size() > 0 && wq1[0].cyc < cyc) begin
                    ev = wq1.pop_front();
                    chk("dut1_wr_missed", 0, ev.addr);
                end
                if (eq1.size() > 0 && eq1[0].cyc < cyc) begin
                    ev = eq1.pop_front();
                    chk("dut1_err_missed", 0, 1);
                end
                if (wr_done1) begin
                    if (wq1.size() == 0) begin
                        chk("dut1_wr_unexpected", 1, 0);
                    end else begin
                        ev = wq1.pop_front();
                        chk("dut1_wr_addr", int'(wr_addr1), ev.addr);
                        chk("dut1_wr_cycle", cyc, ev.cyc);
                    end
                end
                if (addr_err1) begin
                    if (eq1.size() == 0) begin
                        chk("dut1_err_unexpected", 1, 0);
                    end else begin
                        ev = eq1.pop_front();
                        chk("dut1_err_cycle", cyc, ev.cyc);
                    end
                end
            end
        end
    end

    // Scoreboard monitor for dut2 write pulses.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wq2.size() > 0 && wq2[0].cyc < cyc) begin
                    ev = wq2.pop_front();
                    chk("dut2_wr_missed", 0, ev.addr);
                end
                if (wr_done2) begin
                    if (wq2.size() == 0) begin
                        chk("dut2_wr_unexpected", 1, 0);
                    end else begin
                        ev = wq2.pop_front();
                        chk("dut2_wr_addr", int'(wr_addr2), ev.addr);
                        chk("dut2_wr_cycle", cyc, ev.cyc);
                    end
                end
                if (addr_err2) chk("dut2_err_unexpected", 1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, w;
        int t3[4][4];
        int e3[4][2];
        t3 = '{'{10, 20, 12, -20}, '{-3, 5, -4, 6}, '{0, 0, 1, 1}, '{7, -7, 9, -9}};
        e3 = '{'{11, 0}, '{RND ? -3 : -4, RND ? 6 : 5}, '{RND ? 1 : 0, RND ? 1 : 0}, '{8, -8}};
        b1.in_valid = 1'b0; b1.in_addr = '0; b1.in_re = '0; b1.in_im = '0;
        b2.in_valid = 1'b0; b2.in_addr = '0; b2.in_re = '0; b2.in_im = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(b1.in_ready), 1);
        chk("rst_wr_done", int'(wr_done1), 0);
        chk("rst_wr_addr", int'(wr_addr1), 0);
        rst = 1'b0;
        tick(1);
        chk("idle_in_ready", int'(b1.in_ready), 1);
        chk("idle_bank_full", int'(bank_full1), 0);
        chk("idle_addr_err", int'(addr_err1), 0);
        for (int a = 0; a < 4; a++) readchk(1'b0, a, 0, 0, "idle_rd");
        tick(1);

        // Basic pair to slot 2
        pair1(2, 100, -7, 101, -8);
        idle();
        tick(1);
        readchk(1'b0, 2, RND ? 101 : 100, RND ? -7 : -8, "pair_slot2");
        tick(1);

        // Fill all slots, then clear
        for (int a = 0; a < 4; a++) begin
            pair1(a, t3[a][0], t3[a][1], t3[a][2], t3[a][3]);
            if (a == 3) chk("full_before_last", int'(bank_full1), 0);
        end
        idle();
        tick(1);
        chk("bank_full_set", int'(bank_full1), 1);
        for (int a = 0; a < 4; a++) readchk(1'b0, a, e3[a][0], e3[a][1], "fill_rd");
        tick(1);

        // Clear with a same-cycle sample: the sample is dropped
        clr1 = 1'b1;
        send(1'b0, 0, 1000, 1000, k, w);
        clr1 = 1'b0;
        idle();
        chk("clear_bank_full", int'(bank_full1), 0);
        for (int a = 0; a < 4; a++) readchk(1'b0, a, 0, 0, "clear_rd");
        tick(1);
        pair1(0, 4, 6, 6, 8);
        idle();
        tick(1);
        readchk(1'b0, 0, 5, 7, "post_clear_slot0");
        tick(1);

        // Address change mid-group
        send(1'b0, 1, 50, 50, k, w);
        send(1'b0, 3, 10, 20, k, w);
        eq1.push_back('{addr: 3, cyc: k + 1});
        send(1'b0, 3, 12, 22, k, w);
        wq1.push_back('{addr: 3, cyc: k + 1});
        idle();
        tick(1);
        readchk(1'b0, 1, 0, 0, "abort_slot1");
        readchk(1'b0, 3, 11, 21, "regroup_slot3");
        tick(1);

        // Saturation extremes and out-of-range slot on dut2
        quad2(0, 32767, 32767);
        idle();
        tick(1);
        readchk(1'b1, 0, 32767, 32767, "max_slot0");
        tick(1);
        quad2(0, -32768, -32768);
        idle();
        tick(1);
        readchk(1'b1, 0, -32768, -32768, "min_slot0");
        tick(1);
        quad2(3, 5, 5);
        idle();
        tick(1);
        readchk(1'b1, 3, 0, 0, "oob_rd3");
        readchk(1'b1, 0, -32768, -32768, "oob_slot0_kept");
        chk("oob_bank_full", int'(bank_full2), 0);
        tick(1);

        // Reset mid-group
        send(1'b0, 2, 300, 300, k, w);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(b1.in_ready), 1);
        chk("midrst_wr_done", int'(wr_done1), 0);
        chk("midrst_bank_full", int'(bank_full1), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        readchk(1'b0, 2, 0, 0, "midrst_slot2");
        tick(1);

        // Back-to-back groups: third sample stalls through the write cycle
        send(1'b0, 1, 2, 2, k, w);
        chk("b2b_wait0", w, 0);
        send(1'b0, 1, 4, 4, k, w);
        wq1.push_back('{addr: 1, cyc: k + 1});
        chk("b2b_wr_ready", int'(b1.in_ready), 0);
        send(1'b0, 1, 6, 6, k, w);
        chk("b2b_stall", w, 1);
        send(1'b0, 1, 8, 8, k, w);
        wq1.push_back('{addr: 1, cyc: k + 1});
        idle();
        tick(1);
        readchk(1'b0, 1, 7, 7, "b2b_slot1");

        tick(3);
        chk("dut1_wq_empty", wq1.size(), 0);
        chk("dut1_eq_empty", eq1.size(), 0);
        chk("dut2_wq_empty", wq2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
